// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering load/store requests over valid/ready
// request and response channels, with a programmable number of wait states.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        startin,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          lat_write;
  logic [31:0]   lat_addr, lat_wdata;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, enter_resp;
  logic          cur_write, cur_err;
  logic [31:0]   cur_addr, cur_wdata;
  logic [AW-1:0] cur_idx;

  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  // With zero wait states RESP is entered on the accepting edge itself, so
  // the live request fields stand in for the not-yet-latched copies.
  assign cur_write = (state == IDLE) ? req_write : lat_write;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign cur_idx   = cur_addr[AW+1:2];
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (|cur_addr[31:AW+2]);

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_INIT;
      else if ((state == WAIT) && (cnt != 4'd0))
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Response data is captured once on RESP entry and held until the handshake.
  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= cur_err;
      rsp_rdata <= (cur_write || cur_err) ? 32'd0 : mem[cur_idx];
    end
  end

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      for (int k = 0; k < DEPTH_WORDS; k++) mem[k] <= 32'd0;
    end else if (enter_resp && cur_write && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states
// (index 0, manual rsp_ready) and one with none (index 1, rsp_ready tied high).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        startin;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc, prev_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .startin(startin),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .startin(startin),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction; latency is counted in edges from the accepting
  // edge to the first edge that sees rsp_valid high (WAIT_CYCLES+1).
  task automatic txn(input int i, input string tag, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er,
                     input int hold, output int acc_cyc);
    int guard;
    int lat;
    int w;
    w = (i == 0) ? 2 : 0;
    acc_cyc = 0;
    @(negedge clk);
    guard = 0;
    while (!req_ready[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[i]) begin
      chk({tag, " req_ready timeout"}, {31'd0, req_ready[i]}, 32'd1);
      return;
    end
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid[i] = 1'b0;
    req_write[i] = ~wr;
    req_addr[i]  = ~a;
    req_wdata[i] = ~wd;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[i]) begin
      chk({tag, " rsp_valid timeout"}, {31'd0, rsp_valid[i]}, 32'd1);
      return;
    end
    chk({tag, " latency"}, lat, w + 1);
    chk({tag, " rdata"}, rsp_rdata[i], exp_rd);
    chk({tag, " err"}, {31'd0, rsp_err[i]}, {31'd0, exp_er});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk($sformatf("%s hold%0d valid", tag, k), {31'd0, rsp_valid[i]}, 32'd1);
      chk($sformatf("%s hold%0d rdata", tag, k), rsp_rdata[i], exp_rd);
      chk($sformatf("%s hold%0d err", tag, k), {31'd0, rsp_err[i]}, {31'd0, exp_er});
      chk($sformatf("%s hold%0d req_ready", tag, k), {31'd0, req_ready[i]}, 32'd0);
    end
    if (i == 0) rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    if (i == 0) rsp_ready[0] = 1'b0;
    chk({tag, " valid drop"}, {31'd0, rsp_valid[i]}, 32'd0);
    chk({tag, " ready back"}, {31'd0, req_ready[i]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running want=done");
    $fatal(1, "watchdog");
  end

  initial begin
    startin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b1;

    // asynchronous reset in the middle of a cycle
    #3 startin = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d req_ready", i), {31'd0, req_ready[i]}, 32'd1);
      chk($sformatf("rst%0d rsp_valid", i), {31'd0, rsp_valid[i]}, 32'd0);
      chk($sformatf("rst%0d rsp_rdata", i), rsp_rdata[i], 32'd0);
      chk($sformatf("rst%0d rsp_err", i), {31'd0, rsp_err[i]}, 32'd0);
    end
    @(negedge clk);
    startin = 1'b1;

    txn(0, "ld0 after rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, acc);
    txn(0, "st 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, acc);
    txn(0, "ld 0x10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, acc);
    txn(0, "st 0x4", 1'b1, 32'h4, 32'h11111111, 32'h0, 1'b0, 0, acc);
    txn(0, "ld 0x4", 1'b0, 32'h4, 32'h0, 32'h11111111, 1'b0, 0, acc);
    txn(0, "ld misalign", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 0, acc);
    txn(0, "st range", 1'b1, 32'h404, 32'hCAFEF00D, 32'h0, 1'b1, 0, acc);
    txn(0, "ld 0x4 again", 1'b0, 32'h4, 32'h0, 32'h11111111, 1'b0, 0, acc);
    txn(0, "ld bp", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, acc);

    // store interrupted by reset while waiting
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("mid wait req_ready", {31'd0, req_ready[0]}, 32'd0);
    #2 startin = 1'b0;
    #1;
    chk("mid rst req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("mid rst rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("mid rst rsp_rdata", rsp_rdata[0], 32'd0);
    chk("mid rst rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    @(negedge clk);
    startin = 1'b1;
    txn(0, "ld 0x20 dropped", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0, acc);
    txn(0, "ld 0x10 cleared", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0, acc);

    // zero wait states, back-to-back with rsp_ready tied high
    prev_acc = -1;
    for (int k = 0; k < 16; k++) begin
      txn(1, $sformatf("w0 st%0d", k), 1'b1, 32'(k * 4), 32'hC0DE0000 + 32'(k),
          32'h0, 1'b0, 0, acc);
      if (prev_acc >= 0) chk($sformatf("w0 st%0d spacing", k), acc - prev_acc, 2);
      prev_acc = acc;
      txn(1, $sformatf("w0 ld%0d", k), 1'b0, 32'(k * 4), 32'h0,
          32'hC0DE0000 + 32'(k), 1'b0, 0, acc);
      chk($sformatf("w0 ld%0d spacing", k), acc - prev_acc, 2);
      prev_acc = acc;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
